// File: rtl/junction_lamp_drv.sv
// Lamp and 4-digit 7-seg driver behind the intersection phase controller.
// Optional `LAMP_TEST_EN adds lamp_test_i, forcing every lamp on and every digit to "8".
module junction_lamp_drv #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       svc_en_i,
  input  logic       wait_idle_i,
  input  logic [4:0] w_i,
  input  logic [4:0] tranzit_i,
  input  logic [7:0] count_i,
`ifdef LAMP_TEST_EN
  input  logic       lamp_test_i,
`endif
  output logic [2:0] lamp_n_o,
  output logic [2:0] lamp_e_o,
  output logic [2:0] lamp_v_o,
  output logic [2:0] lamp_s_o,
  output logic [1:0] lamp_p_o,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       fault_o
);

  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
`ifdef LAMP_TEST_EN
  localparam int unsigned IW = 21;
`else
  localparam int unsigned IW = 20;
`endif

  typedef enum logic [1:0] {BCD_IDLE, BCD_LOAD, BCD_SHIFT, BCD_DONE} bcd_state_e;

  logic [IW-1:0] raw, syn;
  logic [SYNC_STAGES-1:0][IW-1:0] sync_q, sync_d;
  logic       svc_s, idle_s, conflict, fault_any;
  logic [4:0] w_s, tr_s;
  logic [7:0] cnt_s;
  logic [2:0] lamp_n_q, lamp_n_d, lamp_e_q, lamp_e_d, lamp_v_q, lamp_v_d, lamp_s_q, lamp_s_d;
  logic [1:0] lamp_p_q, lamp_p_d;
  logic       fault_q, fault_d, blink_q, blink_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0] dig_q, dig_d;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d, letter;
  bcd_state_e state_q, state_d;
  logic [2:0]  sh_cnt_q, sh_cnt_d;
  logic [19:0] sr_q, sr_d, sr_adj;
  logic [7:0]  cap_q, cap_d;
  logic [11:0] bcd_q, bcd_d;

`ifdef LAMP_TEST_EN
  logic test_s;
  assign raw    = {lamp_test_i, count_i, tranzit_i, w_i, wait_idle_i, svc_en_i};
  assign test_s = syn[20];
`else
  assign raw = {count_i, tranzit_i, w_i, wait_idle_i, svc_en_i};
`endif
  assign syn    = sync_q[SYNC_STAGES-1];
  assign svc_s  = syn[0];
  assign idle_s = syn[1];
  assign w_s    = syn[6:2];
  assign tr_s   = syn[11:7];
  assign cnt_s  = syn[19:12];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], raw};

  // The conflicting cycle itself already forces all-red, not only the cycle after.
  assign conflict  = svc_s && ((w_s & (w_s - 5'd1)) != 5'd0);
  assign fault_any = fault_q || conflict;
  assign fault_d   = fault_any;

  function automatic logic [6:0] seg7_digit(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  always_comb begin
    lamp_n_d = 3'b100;
    lamp_e_d = 3'b100;
    lamp_v_d = 3'b100;
    lamp_s_d = 3'b100;
    lamp_p_d = 2'b10;
    letter   = 7'h7F;
    if (fault_any) begin
      letter = 7'h0E;
    end else if (!svc_s) begin
      lamp_n_d = {1'b0, blink_q, 1'b0};
      lamp_e_d = {1'b0, blink_q, 1'b0};
      lamp_v_d = {1'b0, blink_q, 1'b0};
      lamp_s_d = {1'b0, blink_q, 1'b0};
      lamp_p_d = 2'b00;
    end else if (w_s[4]) begin
      lamp_p_d = 2'b01; letter = 7'h0C;
    end else if (w_s[0])  begin lamp_n_d = 3'b001; letter = 7'h2B; end
    else if (w_s[1])      begin lamp_e_d = 3'b001; letter = 7'h06; end
    else if (w_s[2])      begin lamp_v_d = 3'b001; letter = 7'h63; end
    else if (w_s[3])      begin lamp_s_d = 3'b001; letter = 7'h12; end
    else if (tr_s[0])     begin lamp_n_d = 3'b010; letter = 7'h2B; end
    else if (tr_s[1])     begin lamp_e_d = 3'b010; letter = 7'h06; end
    else if (tr_s[2])     begin lamp_v_d = 3'b010; letter = 7'h63; end
    else if (tr_s[3])     begin lamp_s_d = 3'b010; letter = 7'h12; end
    else if (tr_s[4])     begin lamp_n_d = 3'b110; letter = 7'h07; end
    else if (idle_s)      letter = 7'h3F;
`ifdef LAMP_TEST_EN
    if (test_s) begin
      lamp_n_d = '1; lamp_e_d = '1; lamp_v_d = '1; lamp_s_d = '1; lamp_p_d = '1;
    end
`endif
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    blink_d     = blink_q;
    if (svc_s) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  always_comb begin
    ref_cnt_d = ref_cnt_q + RW'(1);
    dig_d     = dig_q;
    if (ref_cnt_q == RW'(REFRESH_DIV - 1)) begin
      ref_cnt_d = '0;
      dig_d     = dig_q + 2'd1;
    end
    an_d  = ~(4'b0001 << dig_q);
    seg_d = 7'h7F;
    case (dig_q)
      2'd0: seg_d = fault_any ? 7'h3F : seg7_digit(bcd_q[3:0]);
      2'd1: seg_d = fault_any ? 7'h3F : (bcd_q[11:4] == 8'd0) ? 7'h7F : seg7_digit(bcd_q[7:4]);
      2'd2: seg_d = fault_any ? 7'h3F : (bcd_q[11:8] == 4'd0) ? 7'h7F : seg7_digit(bcd_q[11:8]);
      2'd3: seg_d = letter;
    endcase
    if (!svc_s && !fault_any) begin
      an_d  = '1;
      seg_d = '1;
    end
`ifdef LAMP_TEST_EN
    if (test_s) begin
      an_d  = ~(4'b0001 << dig_q);
      seg_d = '0;
    end
`endif
  end

  always_comb begin
    sr_adj = sr_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sr_q[8 + i*4 +: 4] >= 4'd5) sr_adj[8 + i*4 +: 4] = sr_q[8 + i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d  = state_q;
    sh_cnt_d = sh_cnt_q;
    sr_d     = sr_q;
    cap_d    = cap_q;
    bcd_d    = bcd_q;
    case (state_q)
      BCD_IDLE: if (cnt_s != cap_q) state_d = BCD_LOAD;
      BCD_LOAD: begin
        cap_d    = cnt_s;
        sr_d     = {12'd0, cnt_s};
        sh_cnt_d = '0;
        state_d  = BCD_SHIFT;
      end
      BCD_SHIFT: begin
        if (cnt_s != cap_q) begin
          state_d = BCD_LOAD;
        end else begin
          sr_d     = sr_adj << 1;
          sh_cnt_d = sh_cnt_q + 3'd1;
          if (sh_cnt_q == 3'd7) state_d = BCD_DONE;
        end
      end
      BCD_DONE: begin
        bcd_d   = sr_q[19:8];
        state_d = (cnt_s != cap_q) ? BCD_LOAD : BCD_IDLE;
      end
      default: state_d = BCD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q      <= '0;
      lamp_n_q    <= '0;
      lamp_e_q    <= '0;
      lamp_v_q    <= '0;
      lamp_s_q    <= '0;
      lamp_p_q    <= '0;
      fault_q     <= 1'b0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
      ref_cnt_q   <= '0;
      dig_q       <= '0;
      an_q        <= '1;
      seg_q       <= '1;
      state_q     <= BCD_IDLE;
      sh_cnt_q    <= '0;
      sr_q        <= '0;
      cap_q       <= '0;
      bcd_q       <= '0;
    end else begin
      sync_q      <= sync_d;
      lamp_n_q    <= lamp_n_d;
      lamp_e_q    <= lamp_e_d;
      lamp_v_q    <= lamp_v_d;
      lamp_s_q    <= lamp_s_d;
      lamp_p_q    <= lamp_p_d;
      fault_q     <= fault_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      ref_cnt_q   <= ref_cnt_d;
      dig_q       <= dig_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      state_q     <= state_d;
      sh_cnt_q    <= sh_cnt_d;
      sr_q        <= sr_d;
      cap_q       <= cap_d;
      bcd_q       <= bcd_d;
    end
  end

  assign lamp_n_o = lamp_n_q;
  assign lamp_e_o = lamp_e_q;
  assign lamp_v_o = lamp_v_q;
  assign lamp_s_o = lamp_s_q;
  assign lamp_p_o = lamp_p_q;
  assign an_o     = an_q;
  assign seg_o    = seg_q;
  assign fault_o  = fault_q;

endmodule

// File: tb/tb_junction_lamp_drv.sv
// Scoreboard bench for junction_lamp_drv: timed lamp/flag expectations plus whole display frames.
`timescale 1ns/1ps
module tb_junction_lamp_drv;

  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, RY = 3'b110, OFF = 3'b000;
  localparam logic [1:0] PR = 2'b10, PG = 2'b01, POFF = 2'b00;
  localparam logic [6:0] BLANK = 7'h7F, DASH = 7'h3F;
  localparam logic [6:0] S_0 = 7'h40, S_1 = 7'h79, S_2 = 7'h24, S_4 = 7'h19, S_5 = 7'h12;
  localparam logic [6:0] S_6 = 7'h02, S_7 = 7'h78, S_8 = 7'h00;
  localparam logic [6:0] L_N = 7'h2B, L_E = 7'h06, L_V = 7'h63, L_P = 7'h0C, L_T = 7'h07, L_F = 7'h0E;

  logic clk = 1'b0;
  logic rst_n, svc_en, wait_idle;
  logic [4:0] w, tr;
  logic [7:0] cnt;
  logic [2:0] lamp_n, lamp_e, lamp_v, lamp_s;
  logic [1:0] lamp_p;
  logic [3:0] an;
  logic [6:0] seg;
  logic fault;

  always #5 clk = ~clk;

  junction_lamp_drv #(.SYNC_STAGES(2), .REFRESH_DIV(4), .BLINK_DIV(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .svc_en_i(svc_en), .wait_idle_i(wait_idle),
    .w_i(w), .tranzit_i(tr), .count_i(cnt),
    .lamp_n_o(lamp_n), .lamp_e_o(lamp_e), .lamp_v_o(lamp_v), .lamp_s_o(lamp_s),
    .lamp_p_o(lamp_p), .an_o(an), .seg_o(seg), .fault_o(fault)
  );

  typedef struct { int unsigned due; int sel; logic [6:0] exp; } tchk_t;
  tchk_t tq[$];
  logic [27:0] dq[$];
  int unsigned cyc = 0;
  int checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] sig(input int sel);
    case (sel)
      0: return {4'b0, lamp_n};
      1: return {4'b0, lamp_e};
      2: return {4'b0, lamp_v};
      3: return {4'b0, lamp_s};
      4: return {5'b0, lamp_p};
      5: return {6'b0, fault};
      6: return {3'b0, an};
      default: return seg;
    endcase
  endfunction

  function automatic string sname(input int sel);
    case (sel)
      0: return "lamp_n"; 1: return "lamp_e"; 2: return "lamp_v"; 3: return "lamp_s";
      4: return "lamp_p"; 5: return "fault";  6: return "an";     default: return "seg";
    endcase
  endfunction

  always @(negedge clk) begin : mon_timed
    tchk_t keep[$];
    keep = {};
    foreach (tq[i]) begin
      if (tq[i].due == cyc) begin
        checks++;
        if (sig(tq[i].sel) !== tq[i].exp) begin
          errors++;
          $display("FAIL %s @cyc %0d: got %h expected %h", sname(tq[i].sel), cyc, sig(tq[i].sel), tq[i].exp);
        end
      end else if (tq[i].due < cyc) begin
        checks++; errors++;
        $display("FAIL %s @cyc %0d: missed, expected %h", sname(tq[i].sel), tq[i].due, tq[i].exp);
      end else begin
        keep.push_back(tq[i]);
      end
    end
    tq = keep;
  end

  logic [3:0] prev_an = 4'hF;
  int pos = 0;
  bit cap_on = 1'b0;
  logic [27:0] frame;

  always @(negedge clk) begin : mon_disp
    logic [3:0] ea;
    logic [27:0] ef;
    if (dq.size() != 0) begin
      if (!cap_on) begin
        if (an == 4'b1110 && prev_an != 4'b1110) begin
          cap_on = 1'b1; pos = 0; frame[6:0] = seg;
        end
      end else if (an != prev_an) begin
        pos++;
        ea = 4'b0001 << pos;
        ea = ~ea;
        checks++;
        if (an !== ea) begin
          errors++;
          $display("FAIL an_seq @cyc %0d: got %b expected %b", cyc, an, ea);
        end
        if (pos <= 3) frame[pos*7 +: 7] = seg;
        if (pos >= 3) begin
          ef = dq.pop_front();
          for (int d = 0; d < 4; d++) begin
            checks++;
            if (frame[d*7 +: 7] !== ef[d*7 +: 7]) begin
              errors++;
              $display("FAIL disp_d%0d @cyc %0d: got %h expected %h", d, cyc, frame[d*7 +: 7], ef[d*7 +: 7]);
            end
          end
          cap_on = 1'b0;
        end
      end
    end
    prev_an = an;
  end

  task automatic chk(input int unsigned off, input int sel, input logic [6:0] exp);
    tchk_t t;
    t.due = cyc + off; t.sel = sel; t.exp = exp;
    tq.push_back(t);
  endtask

  task automatic chk_lamps(input int unsigned off, input logic [2:0] n, e, v, s, input logic [1:0] p);
    chk(off, 0, {4'b0, n}); chk(off, 1, {4'b0, e}); chk(off, 2, {4'b0, v});
    chk(off, 3, {4'b0, s}); chk(off, 4, {5'b0, p});
  endtask

  task automatic wait_tq();
    int unsigned n = 0;
    while (tq.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (tq.size() != 0) begin
      checks++; errors++;
      $display("FAIL timed_timeout: %0d pending, required 0", tq.size());
      tq.delete();
    end
  endtask

  task automatic expect_frame(input logic [6:0] d3, d2, d1, d0);
    int unsigned n = 0;
    dq.push_back({d3, d2, d1, d0});
    while (dq.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (dq.size() != 0) begin
      checks++; errors++;
      $display("FAIL frame_timeout: no frame captured, required %h", {d3, d2, d1, d0});
      dq.delete();
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; svc_en = 1'b1; wait_idle = 1'b0; w = '0; tr = '0; cnt = '0;
    step(2);
    chk_lamps(1, OFF, OFF, OFF, OFF, POFF);
    chk(1, 5, 7'd0); chk(1, 6, 7'h0F); chk(1, 7, 7'h7F);
    wait_tq();
    @(negedge clk); rst_n = 1'b1;
    chk_lamps(3, R, R, R, R, PR);
    wait_tq(); step(4);
    expect_frame(BLANK, BLANK, BLANK, S_0);

    @(negedge clk); w = 5'b00001; cnt = 8'd18;
    chk(2, 0, {4'b0, R});
    chk_lamps(3, G, R, R, R, PR);
    wait_tq(); step(14);
    expect_frame(L_N, BLANK, S_1, S_8);

    @(negedge clk); cnt = 8'd17;
    @(negedge clk); cnt = 8'd16;
    step(14);
    expect_frame(L_N, BLANK, S_1, S_6);

    @(negedge clk); cnt = 8'd99;
    step(4); cnt = 8'd42;
    step(16);
    expect_frame(L_N, BLANK, S_4, S_2);

    @(negedge clk); cnt = 8'd255; step(14);
    expect_frame(L_N, S_2, S_5, S_5);
    @(negedge clk); cnt = 8'd100; step(14);
    expect_frame(L_N, S_1, S_0, S_0);
    @(negedge clk); cnt = 8'd7; step(14);
    expect_frame(L_N, BLANK, BLANK, S_7);

    @(negedge clk); w = '0; tr = 5'b10000;
    chk_lamps(3, RY, R, R, R, PR); wait_tq(); step(6);
    expect_frame(L_T, BLANK, BLANK, S_7);
    @(negedge clk); tr = '0; w = 5'b10000;
    chk_lamps(3, R, R, R, R, PG); wait_tq(); step(6);
    expect_frame(L_P, BLANK, BLANK, S_7);
    @(negedge clk); w = '0; tr = 5'b00010;
    chk_lamps(3, R, Y, R, R, PR); wait_tq(); step(6);
    expect_frame(L_E, BLANK, BLANK, S_7);
    @(negedge clk); tr = '0; w = 5'b00100;
    chk_lamps(3, R, R, G, R, PR); wait_tq(); step(6);
    expect_frame(L_V, BLANK, BLANK, S_7);
    @(negedge clk); w = '0; wait_idle = 1'b1;
    chk_lamps(3, R, R, R, R, PR); wait_tq(); step(6);
    expect_frame(DASH, BLANK, BLANK, S_7);

    @(negedge clk); wait_idle = 1'b0; w = 5'b00001; step(6);
    @(negedge clk); w = 5'b00011;
    chk(2, 0, {4'b0, G}); chk(2, 5, 7'd0); chk(3, 5, 7'd1);
    chk_lamps(3, R, R, R, R, PR);
    wait_tq(); step(4);
    expect_frame(L_F, DASH, DASH, DASH);
    @(negedge clk); w = 5'b00010;
    chk(3, 5, 7'd1); chk(6, 5, 7'd1); chk(6, 1, {4'b0, R});
    wait_tq();

    @(posedge clk); #2; rst_n = 1'b0;
    chk(0, 5, 7'd0); chk_lamps(0, OFF, OFF, OFF, OFF, POFF);
    chk(0, 6, 7'h0F); chk(0, 7, 7'h7F);
    wait_tq();
    @(negedge clk); w = '0; cnt = '0;
    @(negedge clk); rst_n = 1'b1;
    step(8);

    @(negedge clk); svc_en = 1'b0;
    chk(2, 0, {4'b0, R});
    for (int k = 3; k <= 6; k++) chk(k, 0, {4'b0, OFF});
    for (int k = 7; k <= 10; k++) chk(k, 0, {4'b0, Y});
    for (int k = 11; k <= 14; k++) chk(k, 0, {4'b0, OFF});
    chk(15, 0, {4'b0, Y});
    chk(7, 3, {4'b0, Y}); chk(3, 4, {5'b0, POFF}); chk(9, 4, {5'b0, POFF});
    chk(3, 6, 7'h0F); chk(10, 6, 7'h0F); chk(5, 7, 7'h7F);
    wait_tq();
    @(negedge clk); svc_en = 1'b1;
    chk_lamps(3, R, R, R, R, PR); chk(3, 5, 7'd0);
    wait_tq(); step(4);
    expect_frame(BLANK, BLANK, BLANK, S_0);

    wait_tq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required finish before 200us");
    $fatal(1, "watchdog expired");
  end

endmodule
